mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 3072, meaning the number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port req_valid  in  1  pipeline presents a memory operation.
REQ-005 SHALL have port req_ready  out  1  unit can accept; high only in IDLE.
REQ-006 SHALL have port req_op  in  3  operation code (LW, LH, LHU, LB, LBU, SW, SH, SB).
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data, right-aligned for SH/SB.
REQ-009 SHALL have port resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-010 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err  out  1  misaligned or out-of-range access.
REQ-012 SHALL have port mem_we  out  1, mem_addr  out  16 (byte address), mem_wd  out  32, mem_rd  in  32  word port to data memory (combinational read, write on clk edge).

Function
REQ-013 SHALL implement states IDLE, ACCESS, MERGE, RESP.
REQ-014 SHALL accept a request on a clk edge with req_valid && req_ready, latching op, addr, wdata; IDLE->ACCESS, or IDLE->RESP on error.
REQ-015 SHALL flag an error when LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0, or addr >= MEM_WORDS*4; errored ops never assert mem_we.
REQ-016 SHALL drive mem_addr = latched addr[15:0] from ACCESS through MERGE.
REQ-017 In ACCESS for loads: SHALL capture mem_rd, select lane (little-endian: addr[1:0]=0 -> bits 7:0; addr[1]=0 -> bits 15:0), sign-extend LB/LH, zero-extend LBU/LHU, then go to RESP.
REQ-018 In ACCESS for SW: SHALL assert mem_we with mem_wd = wdata for exactly that cycle, then go to RESP.
REQ-019 In ACCESS for SH/SB: SHALL capture mem_rd without writing, then go to MERGE.
REQ-020 In MERGE: SHALL assert mem_we for one cycle with mem_wd = captured word with only the addressed byte/halfword replaced by wdata[7:0]/[15:0], then go to RESP.
REQ-021 Latency from accept edge to resp_valid high: SHALL be 2 cycles for loads and SW, 3 for SH/SB, and 1 for errors.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready; on handshake go to IDLE and clear resp_valid.
REQ-023 SHALL keep req_ready low outside IDLE; a req_valid coinciding with a response handshake is accepted no earlier than the following cycle.
REQ-024 SHALL decode mem_we from state only (ACCESS with SW, or MERGE), never from inputs directly.

Reset
REQ-025 While reset=0: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0; takes effect without a clk edge.
REQ-026 Reset mid-operation SHALL abandon the op and deassert mem_we immediately; a partial SH/SB SHALL leave memory unmodified.
REQ-027 SHALL have req_ready=1 from the first cycle after reset release.

Structure
REQ-028 SHALL place the op-code encoding (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7) and the state encoding in shared package mau_pkg.
REQ-029 SHALL place lane extract/extend and lane merge in one combinational sub-module, mau_lane.

Verification
REQ-030 Check: mem word 0x10 = 0x8765_4321, LB addr 0x11 -> resp_rdata 0x0000_0043, resp_valid 2 cycles after accept; LH addr 0x12 -> 0xFFFF_8765; LHU addr 0x12 -> 0x0000_8765.
REQ-031 Check: SB addr 0x13 wdata 0xAA onto word 0x1122_3344 -> single mem_we pulse in MERGE, mem_wd 0xAA22_3344, resp 3 cycles after accept.
REQ-032 Check: LW addr 0x6 and SW addr 0x3000 -> resp_err=1, resp_rdata=0, mem_we never high, resp 1 cycle after accept.
REQ-033 Check: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready low throughout; back-to-back req_valid is accepted the cycle after the handshake.
REQ-034 Check: reset=0 asserted between clk edges during MERGE of SH addr 0x20 -> mem_we falls at once, word 0x20 unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: op codes, FSM states, alignment check.
package mau_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_MERGE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte/halfword lane handling: load extract + extend, and sub-word store merge.
module mau_lane
  import mau_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h0;
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h0;
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_ldata = 32'h0;
    case (i_op)
      OP_LW:   o_ldata = i_word;
      OP_LH:   o_ldata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ldata = {16'h0, w_half};
      OP_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ldata = {24'h0, w_byte};
      default: o_ldata = 32'h0;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    if (i_op == OP_SB) begin
      case (i_addr_lo)
        2'd0: o_merged[7:0]   = i_wdata[7:0];
        2'd1: o_merged[15:8]  = i_wdata[7:0];
        2'd2: o_merged[23:16] = i_wdata[7:0];
        2'd3: o_merged[31:24] = i_wdata[7:0];
        default: o_merged = i_word;
      endcase
    end else if (i_op == OP_SH) begin
      if (i_addr_lo[1]) o_merged[31:16] = i_wdata;
      else              o_merged[15:0]  = i_wdata;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Sub-word stores are read-modify-write: read in ACCESS, write merged word in MERGE.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_valid;

  logic        w_err;
  logic        w_is_load;
  logic [31:0] w_lane_word;
  logic [31:0] w_ldata;
  logic [31:0] w_merged;

  assign w_err = misaligned(req_op, req_addr[1:0]) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign w_is_load = (r_op < OP_SW);

  // MERGE works on the word captured in ACCESS; loads extract straight from memory.
  assign w_lane_word = (r_state == ST_MERGE) ? r_word : mem_rd;

  mau_lane u_lane (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (w_lane_word),
    .i_wdata   (r_wdata[15:0]),
    .o_ldata   (w_ldata),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr[15:0];
            r_wdata <= req_wdata;
            if (w_err) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (w_is_load || r_op == OP_SW) begin
            r_rdata <= w_is_load ? w_ldata : 32'h0;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_word  <= mem_rd;
            r_state <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is a pure state decode so an async reset drops the write at once.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (r_state == ST_ACCESS) begin
      mem_addr = r_addr;
      if (r_op == OP_SW) begin
        mem_we = 1'b1;
        mem_wd = r_wdata;
      end
    end else if (r_state == ST_MERGE) begin
      mem_addr = r_addr;
      mem_we   = 1'b1;
      mem_wd   = w_merged;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a response scoreboard.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int MW = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = OP_LW;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[15:2]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and return at the negedge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int elat);
    int w;
    sbq.push_back('{erd, eerr, elat});
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    chk("accept_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge (latency 1 point).
  task automatic recv(input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    chk("resp_valid", {31'h0, resp_valid}, 32'h1);
    if (sbq.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sbq.pop_front();
      chk("latency", 32'(lat), 32'(e.lat));
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'h0, resp_valid}, 32'h1);
        chk("hold_rdata", resp_rdata, e.rdata);
        chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_hs_valid", {31'h0, resp_valid}, 32'h0);
    chk("post_hs_ready", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
    mem[4]    <= 32'h8765_4321;
    mem[8]    <= 32'h5566_7788;
    mem[MW-1] <= 32'hCAFE_F00D;

    // asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // loads with lane select and extension
    send(OP_LB,  32'h11, 32'h0, 32'h0000_0043, 1'b0, 2); recv(0);
    send(OP_LH,  32'h12, 32'h0, 32'hFFFF_8765, 1'b0, 2); recv(0);
    send(OP_LHU, 32'h12, 32'h0, 32'h0000_8765, 1'b0, 2); recv(0);
    send(OP_LBU, 32'h13, 32'h0, 32'h0000_0087, 1'b0, 2); recv(0);
    send(OP_LB,  32'h13, 32'h0, 32'hFFFF_FF87, 1'b0, 2); recv(0);
    send(OP_LW,  32'h10, 32'h0, 32'h8765_4321, 1'b0, 2); recv(0);

    // full-word store
    c0 = we_cnt;
    send(OP_SW, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 2); recv(0);
    chk("sw_we_count", 32'(we_cnt - c0), 32'h1);
    chk("sw_mem", mem[4], 32'h1122_3344);

    // sub-word stores: read-modify-write
    c0 = we_cnt;
    send(OP_SB, 32'h13, 32'h0000_00AA, 32'h0, 1'b0, 3); recv(0);
    chk("sb_we_count", 32'(we_cnt - c0), 32'h1);
    chk("sb_mem_wd", last_wd, 32'hAA22_3344);
    chk("sb_mem", mem[4], 32'hAA22_3344);
    send(OP_SH, 32'h16, 32'h1234_BEEF, 32'h0, 1'b0, 3); recv(0);
    send(OP_SB, 32'h14, 32'hFFFF_FF5A, 32'h0, 1'b0, 3); recv(0);
    chk("sh_sb_mem", mem[5], 32'hBEEF_005A);
    send(OP_LH, 32'h16, 32'h0, 32'hFFFF_BEEF, 1'b0, 2); recv(0);

    // errors: misaligned and out of range, no writes
    c0 = we_cnt;
    send(OP_LW, 32'h6,    32'h0,         32'h0, 1'b1, 1); recv(0);
    send(OP_SW, 32'h3000, 32'hDEAD_BEEF, 32'h0, 1'b1, 1); recv(0);
    send(OP_LH, 32'h11,   32'h0,         32'h0, 1'b1, 1); recv(0);
    send(OP_SH, 32'h15,   32'h0000_1111, 32'h0, 1'b1, 1); recv(0);
    chk("err_we_count", 32'(we_cnt - c0), 32'h0);
    chk("err_mem_oob", mem[MW], 32'h0);
    chk("err_mem_5", mem[5], 32'hBEEF_005A);

    // last valid word
    send(OP_LW,  32'h2FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2); recv(0);
    send(OP_LBU, 32'h2FFF, 32'h0, 32'h0000_00CA, 1'b0, 2); recv(0);

    // response backpressure, then a request waiting through the handshake
    send(OP_LW, 32'h10, 32'h0, 32'hAA22_3344, 1'b0, 2);
    sbq.push_back('{32'h0000_0044, 1'b0, 2});
    req_valid = 1'b1; req_op = OP_LBU; req_addr = 32'h10; req_wdata = 32'h0;
    recv(5);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_accepted", {31'h0, req_ready}, 32'h0);
    recv(0);

    // reset during MERGE of a halfword store
    c0 = we_cnt;
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h20; req_wdata = 32'h0000_9999;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_access_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rmw_merge_we", {31'h0, mem_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rmw_rst_we", {31'h0, mem_we}, 32'h0);
    chk("rmw_rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rmw_rst_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk("rmw_mem", mem[8], 32'h5566_7788);
    chk("rmw_we_count", 32'(we_cnt - c0), 32'h0);
    @(negedge clk);
    chk("rmw_req_ready", {31'h0, req_ready}, 32'h1);
    send(OP_LW, 32'h20, 32'h0, 32'h5566_7788, 1'b0, 2); recv(0);

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
